jt49_dcrm_mc: RTL and testbench
===============================

Name: jt49_dcrm_mc

Overview:
Time-multiplexed, multi-channel DC-removal high-pass filter for PSG/APU mixer outputs. One integrator/error-feedback core processes CH channels. Per-channel state is held in a register array. The cutoff is selectable at run time, the input can be unsigned or signed, and each channel is "primed" on its first sample so its output starts at zero instead of settling slowly. It sits between the per-channel volume stage and the final mixer.

Parameters:
SW, 8, sample width (input and output)
DW, 10, fractional bits of integrator; maximum time-constant exponent
CH, 3, number of channels (≥1)
CW, 2, channel index width, ≥ clog2(CH)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high; clock clk
cen  in  1  clock enable for the sample path
clr_all  in  1  one-clk pulse: clear all channel states (starts sweep)
signed_in  in  1  0: din unsigned (zero-extend); 1: din two's complement (sign-extend)
tc  in  4  time-constant exponent k; values <4 act as 4, values >DW act as DW
din_valid  in  1  sample present
din_ch  in  CW  channel of sample
din  in  SW  sample
busy  out  1  clear sweep in progress; samples dropped
dout_valid  out  1  output sample valid (one clk pulse)
dout_ch  out  CW  channel of dout
dout  out  SW  signed filtered sample

Behaviour:
- Per-channel state: integ[c] (SW+DW+2 bits, signed), error[c] (same width), primed[c] (1 bit).
- FSM states: CLEAR and IDLE.
  - rst forces CLEAR with sweep counter=0. clr_all in IDLE also enters CLEAR with counter=0.
  - In CLEAR, on every clk (not cen-gated), integ, error and primed are zeroed for index counter, then counter increments.
  - After index CH-1 is cleared, the FSM goes to IDLE. The sweep takes exactly CH clks.
  - clr_all during CLEAR restarts the counter at 0.
- busy=1 in CLEAR.
- Reset values: busy=1, dout_valid=0, dout_ch=0, dout=0.
- Accept condition: IDLE & cen & din_valid & din_ch<CH. If din_ch≥CH, the sample is dropped and state is unchanged. Every sample arriving while busy is dropped.
- One sample may be accepted per cen cycle. Back-to-back samples on the same channel must use the updated state; there is no hazard because read, compute and write-back happen in the same clk.
- Arithmetic on accept, for channel c and k = clamp(tc, 4, DW):
  - x = din extended to SW+1 bits per signed_in.
  - exact = integ[c] + error[c]
  - q = exact[SW+DW+1:DW], arithmetic
  - pre = x - q, computed at SW+2 bits with no loss
  - If primed[c]=0: integ[c] <= x<<<DW, error[c] <= 0, primed[c] <= 1, output 0.
  - Otherwise: integ[c] <= integ[c] + (pre<<<(DW-k)); error[c] <= exact - (q<<<DW); output pre.
- Output registers load at the same clk edge as the accept. Latency: dout_valid=1 on the clk after the accepting edge, for exactly one clk, with dout_ch=c. dout holds its value until the next accept.
- dout = pre[SW-1:0], wrap-around, unless the optional feature is enabled.
- Changing tc or signed_in mid-stream takes effect from the next accepted sample. State is not reset.
- With k=DW and primed, behaviour is bit-exact with the single-channel DW=10 DC remover for in-range results.
- rst mid-stream: the pending dout_valid is cleared at the same edge, and all state is cleared by the sweep.

Optional Feature:
Macro JT49_DCRM_SAT_EN.
- Defined: dout saturates pre to the signed SW range [-2^(SW-1), 2^(SW-1)-1]. A sticky output sat_flag (1 bit, reset 0, cleared by clr_all) is added and set on any clip.
- Undefined: dout wraps to pre[SW-1:0] and no sat_flag port exists.

Test Plan:
- Reset sweep: SW=8, DW=10, CH=3. Release rst, then drive din_valid=1 each clk. busy=1 for exactly 3 clks, no dout_valid during the sweep, and the first accept happens on clk 4.
- Priming and DC rejection: ch0, unsigned, tc=10, constant din=200 for 50 samples. Every dout=0.
- Step response: after priming ch0 at 100, step to 164. First dout=64. dout is monotonically non-increasing, and after 1024 samples dout is 23 or 24 (64·e⁻¹).
- Channel isolation and interleave: alternate ch0=50 and ch1=250 steps, back-to-back on every cen. Each channel's outputs match a single-channel model run on that channel alone. ch2 stays unprimed.
- Mode and clear: signed_in=1, ch2 din=0x80 (-128) primes. Next din=0x7F gives pre=255, so dout=0xFF wraps to -1, or 127 with sat_flag=1 under JT49_DCRM_SAT_EN. Then a clr_all pulse gives busy for 3 clks, and the next ch2 sample re-primes with dout=0.
- Invalid channel and cutoff: din_ch=3 yields no dout_valid and no state change. tc=2 matches tc=4 exactly, and tc=15 matches tc=10.

Source files
------------

// File: rtl/jt49_dcrm_mc.sv
// jt49_dcrm_mc: time-multiplexed multi-channel DC-removal high-pass filter.
// A single integrator / error-feedback core serves CH channels whose state
// lives in small register arrays. Each channel is primed by its first
// sample so its output starts at zero instead of slowly settling.
// Optional build macro JT49_DCRM_SAT_EN: saturate dout and add sticky sat_flag;
// without it dout wraps to the low SW bits.
module jt49_dcrm_mc #(
  parameter int SW = 8,
  parameter int DW = 10,
  parameter int CH = 3,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          clr_all,
  input  logic          signed_in,
  input  logic [3:0]    tc,
  input  logic          din_valid,
  input  logic [CW-1:0] din_ch,
  input  logic [SW-1:0] din,
  output logic          busy,
  output logic          dout_valid,
  output logic [CW-1:0] dout_ch,
  output logic [SW-1:0] dout
`ifdef JT49_DCRM_SAT_EN
  ,
  output logic          sat_flag
`endif
);

  localparam int IW = SW + DW + 2;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic signed [IW-1:0] integ_mem  [CH];
  logic signed [IW-1:0] err_mem    [CH];
  logic                 primed_mem [CH];

  // Time-constant exponent limited to the range the integrator supports.
  function automatic logic [3:0] clamp_tc(input logic [3:0] t);
    if (t < 4'd4)
      return 4'd4;
    else if (int'(t) > DW)
      return 4'(DW);
    else
      return t;
  endfunction

  // Plain two's-complement wrap to the output width.
  function automatic logic [SW-1:0] wrap_out(input logic signed [SW+1:0] p);
    return p[SW-1:0];
  endfunction

`ifdef JT49_DCRM_SAT_EN
  // Out of range when the top three bits are not all equal.
  function automatic logic clip_det(input logic signed [SW+1:0] p);
    return (|p[SW+1:SW-1]) & ~(&p[SW+1:SW-1]);
  endfunction

  function automatic logic [SW-1:0] sat_out(input logic signed [SW+1:0] p);
    if (!clip_det(p))
      return p[SW-1:0];
    else if (p[SW+1])
      return {1'b1, {(SW-1){1'b0}}};
    else
      return {1'b0, {(SW-1){1'b1}}};
  endfunction
`endif

  logic                 ch_ok_p0;
  logic                 accept_p0;
  logic [CW-1:0]        idx_p0;
  logic signed [IW-1:0] integ_rd_p0;
  logic signed [IW-1:0] err_rd_p0;
  logic                 primed_rd_p0;
  logic signed [SW:0]   x_p0;
  logic signed [IW-1:0] exact_p0;
  logic signed [SW+1:0] q_p0;
  logic signed [SW+1:0] pre_p0;
  logic [3:0]           k_p0;
  logic [3:0]           shamt_p0;
  logic signed [IW-1:0] pre_ext_p0;
  logic signed [IW-1:0] integ_nxt_p0;
  logic signed [IW-1:0] err_nxt_p0;
  logic signed [IW-1:0] prime_integ_p0;
  logic [SW-1:0]        out_p0;
`ifdef JT49_DCRM_SAT_EN
  logic                 clip_p0;
`endif

  // ---- p0: read channel state, compute new state and output in one clk
  // Read, compute and write-back of the selected channel all happen in this
  // clk, so back-to-back samples on one channel always see updated state.
  always_comb begin
    ch_ok_p0       = (int'(din_ch) < CH);
    idx_p0         = ch_ok_p0 ? din_ch : '0;
    accept_p0      = (state == IDLE) & cen & din_valid & ch_ok_p0;
    integ_rd_p0    = integ_mem[idx_p0];
    err_rd_p0      = err_mem[idx_p0];
    primed_rd_p0   = primed_mem[idx_p0];
    x_p0           = signed_in ? {din[SW-1], din} : {1'b0, din};
    exact_p0       = integ_rd_p0 + err_rd_p0;
    q_p0           = exact_p0[IW-1:DW];
    pre_p0         = {x_p0[SW], x_p0} - q_p0;
    k_p0           = clamp_tc(tc);
    shamt_p0       = 4'(DW) - k_p0;
    pre_ext_p0     = {{DW{pre_p0[SW+1]}}, pre_p0};
    integ_nxt_p0   = integ_rd_p0 + (pre_ext_p0 <<< shamt_p0);
    err_nxt_p0     = exact_p0 - {q_p0, {DW{1'b0}}};
    prime_integ_p0 = {x_p0[SW], x_p0, {DW{1'b0}}};
`ifdef JT49_DCRM_SAT_EN
    clip_p0        = primed_rd_p0 & clip_det(pre_p0);
    out_p0         = primed_rd_p0 ? sat_out(pre_p0) : '0;
`else
    out_p0         = primed_rd_p0 ? wrap_out(pre_p0) : '0;
`endif
  end

  // Clear-sweep controller: CLEAR zeroes one channel per clk, then IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (clr_all) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (state == CLEAR) begin
      if (cnt == CW'(CH - 1)) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Per-channel state write-back: sweep clear, priming, or normal update.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      integ_mem[cnt]  <= '0;
      err_mem[cnt]    <= '0;
      primed_mem[cnt] <= 1'b0;
    end else if (accept_p0) begin
      if (!primed_rd_p0) begin
        integ_mem[idx_p0]  <= prime_integ_p0;
        err_mem[idx_p0]    <= '0;
        primed_mem[idx_p0] <= 1'b1;
      end else begin
        integ_mem[idx_p0] <= integ_nxt_p0;
        err_mem[idx_p0]   <= err_nxt_p0;
      end
    end
  end

  // ---- p0 -> p1: output registers, one-clk valid pulse per accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_ch    <= '0;
      dout       <= '0;
    end else begin
      dout_valid <= accept_p0;
      if (accept_p0) begin
        dout_ch <= din_ch;
        dout    <= out_p0;
      end
    end
  end

`ifdef JT49_DCRM_SAT_EN
  // Sticky clip indicator, cleared by reset or clr_all.
  always_ff @(posedge clk) begin
    if (rst || clr_all)
      sat_flag <= 1'b0;
    else if (accept_p0 && clip_p0)
      sat_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_jt49_dcrm_mc.sv
// Directed self-checking bench for jt49_dcrm_mc (SW=8, DW=10, CH=3, CW=2).
// Expected outputs come from hand-computed constants and a small arithmetic
// reference model of the filter kept per channel.
module tb_jt49_dcrm_mc;

  localparam int SW = 8;
  localparam int DW = 10;
  localparam int CH = 3;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          cen;
  logic          clr_all;
  logic          signed_in;
  logic [3:0]    tc;
  logic          din_valid;
  logic [CW-1:0] din_ch;
  logic [SW-1:0] din;
  logic          busy;
  logic          dout_valid;
  logic [CW-1:0] dout_ch;
  logic [SW-1:0] dout;
`ifdef JT49_DCRM_SAT_EN
  logic          sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state (integrator and error in 2^-DW units).
  longint m_i  [CH];
  longint m_e  [CH];
  bit     m_pr [CH];

  jt49_dcrm_mc #(.SW(SW), .DW(DW), .CH(CH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .clr_all   (clr_all),
    .signed_in (signed_in),
    .tc        (tc),
    .din_valid (din_valid),
    .din_ch    (din_ch),
    .din       (din),
    .busy      (busy),
    .dout_valid(dout_valid),
    .dout_ch   (dout_ch),
    .dout      (dout)
`ifdef JT49_DCRM_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model of one accepted sample; k is the effective exponent (already limited).
  task automatic mdl(input int c, input int d, input bit sg, input int k,
                     output int y);
    longint xx, ex, qq, pp;
    xx = (sg && d >= 128) ? longint'(d - 256) : longint'(d);
    if (!m_pr[c]) begin
      m_i[c]  = xx * 1024;
      m_e[c]  = 0;
      m_pr[c] = 1'b1;
      y = 0;
    end else begin
      ex = m_i[c] + m_e[c];
      qq = ex / 1024;
      if ((ex % 1024) != 0 && ex < 0) qq = qq - 1;
      pp = xx - qq;
      m_i[c] = m_i[c] + pp * longint'(1 << (10 - k));
      m_e[c] = ex - qq * 1024;
`ifdef JT49_DCRM_SAT_EN
      if (pp > 127) y = 127;
      else if (pp < -128) y = -128;
      else y = int'(pp);
`else
      y = int'(pp) & 255;
      if (y >= 128) y = y - 256;
`endif
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m_i[c] = 0; m_e[c] = 0; m_pr[c] = 1'b0;
    end
  endtask

  // One sample on one clk; checks the valid pulse and channel, returns dout.
  task automatic send(input int c, input int d, output logic signed [31:0] got);
    din_valid = 1'b1;
    din_ch    = c[CW-1:0];
    din       = d[SW-1:0];
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk("out_valid", dout_valid, 1);
    chk("out_ch", dout_ch, c);
    got = $signed(dout);
  endtask

  // clr_all pulse, then offer a sample on channel c during the sweep.
  task automatic pulse_clear(input int c, input int d);
    din_valid = 1'b0;
    clr_all   = 1'b1;
    @(posedge clk); #1;
    clr_all = 1'b0;
    chk("clr_busy0", busy, 1);
`ifdef JT49_DCRM_SAT_EN
    chk("clr_sat", sat_flag, 0);
`endif
    din_valid = 1'b1;
    din_ch    = c[CW-1:0];
    din       = d[SW-1:0];
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk("clr_busy", busy, (i < 3) ? 1 : 0);
      chk("clr_drop", dout_valid, 0);
    end
    din_valid = 1'b0;
    model_clear();
  endtask

  initial begin
    logic signed [31:0] got;
    logic signed [31:0] held;
    int e;

    rst = 1'b1; cen = 1'b1; clr_all = 1'b0; signed_in = 1'b0; tc = 4'd10;
    din_valid = 1'b0; din_ch = '0; din = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_valid", dout_valid, 0);
    chk("rst_ch", dout_ch, 0);
    chk("rst_dout", $signed(dout), 0);
`ifdef JT49_DCRM_SAT_EN
    chk("rst_sat", sat_flag, 0);
`endif

    // Reset sweep: samples offered every clk are dropped for 3 clks.
    rst = 1'b0;
    din_valid = 1'b1; din_ch = 2'd0; din = 8'd200;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk("sweep_busy", busy, (i < 3) ? 1 : 0);
      chk("sweep_valid", dout_valid, 0);
    end

    // Priming and DC rejection: constant 200 on ch0 gives zeros.
    for (int i = 0; i < 50; i++) begin
      send(0, 200, got);
      mdl(0, 200, 1'b0, 10, e);
      chk("dc_model", got, e);
      chk("dc_zero", got, 0);
    end

    // Step response: prime at 100, step to 164, decays toward 64*e^-1.
    pulse_clear(0, 77);
    send(0, 100, got);
    mdl(0, 100, 1'b0, 10, e);
    chk("step_prime", got, 0);
    for (int i = 1; i <= 1024; i++) begin
      send(0, 164, got);
      mdl(0, 164, 1'b0, 10, e);
      chk("step_model", got, e);
      if (i == 1) chk("step_first", got, 64);
      chk("step_range", (got >= 23 && got <= 64) ? 1 : 0, 1);
    end
    chk("step_end", (got == 23 || got == 24) ? 1 : 0, 1);

    // Interleave ch0 and ch1 back-to-back with a faster cutoff.
    tc = 4'd7;
    send(1, 150, got);
    mdl(1, 150, 1'b0, 7, e);
    chk("il_prime1", got, 0);
    for (int i = 0; i < 30; i++) begin
      send(0, 50, got);
      mdl(0, 50, 1'b0, 7, e);
      chk("il_ch0", got, e);
      send(1, 250, got);
      mdl(1, 250, 1'b0, 7, e);
      chk("il_ch1", got, e);
      if (i == 0) chk("il_ch1_first", got, 100);
    end

    // Signed mode on ch2: -128 primes (ch2 untouched so far), then +127.
    signed_in = 1'b1; tc = 4'd10;
    send(2, 8'h80, got);
    mdl(2, 8'h80, 1'b1, 10, e);
    chk("sg_prime", got, 0);
    send(2, 8'h7F, got);
    mdl(2, 8'h7F, 1'b1, 10, e);
    chk("sg_model", got, e);
`ifdef JT49_DCRM_SAT_EN
    chk("sg_sat", got, 127);
    chk("sg_flag", sat_flag, 1);
`else
    chk("sg_wrap", got, -1);
`endif
    pulse_clear(2, 8'h10);
    send(2, 8'h10, got);
    mdl(2, 8'h10, 1'b1, 10, e);
    chk("reprime", got, 0);

    // Invalid channel and disabled cen: no output, no state change.
    signed_in = 1'b0; tc = 4'd10;
    send(0, 100, got);
    mdl(0, 100, 1'b0, 10, e);
    chk("cut_prime0", got, 0);
    send(1, 100, got);
    mdl(1, 100, 1'b0, 10, e);
    chk("cut_prime1", got, 0);
    held = got;
    din_valid = 1'b1; din_ch = 2'd3; din = 8'd200;
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk("badch_valid", dout_valid, 0);
    chk("badch_hold", $signed(dout), held);
    cen = 1'b0;
    din_valid = 1'b1; din_ch = 2'd0; din = 8'd250;
    @(posedge clk); #1;
    din_valid = 1'b0; cen = 1'b1;
    chk("cen_drop", dout_valid, 0);

    // tc=2 behaves as 4 on ch0, compared against ch1 at tc=4.
    for (int i = 0; i < 15; i++) begin
      tc = 4'd2;
      send(0, 180, got);
      mdl(0, 180, 1'b0, 4, e);
      chk("tc2_model", got, e);
      if (i == 0) chk("tc2_first", got, 80);
      tc = 4'd4;
      send(1, 180, got);
      mdl(1, 180, 1'b0, 4, e);
      chk("tc4_model", got, e);
    end
    // tc=15 behaves as 10.
    for (int i = 0; i < 15; i++) begin
      tc = 4'd15;
      send(0, 40, got);
      mdl(0, 40, 1'b0, 10, e);
      chk("tc15_model", got, e);
      tc = 4'd10;
      send(1, 40, got);
      mdl(1, 40, 1'b0, 10, e);
      chk("tc10_model", got, e);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
